// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus width and FSM state encodings.
package mem_responder_pkg;

    localparam int MEM_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage for the responder: one synchronous write port, one asynchronous read port.
module mem_array #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WORD_SIZE-1:0]  i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WORD_SIZE-1:0]  o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    // No reset on storage: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, completes it after a fixed
// latency with a one-cycle ready pulse, counts accesses and flags protocol errors.
//
// state    | meaning
// MEM_IDLE | no request in flight; preload allowed
// MEM_WAIT | request accepted, latency timer running
// MEM_DONE | ready pulse; write commits and a new request may be accepted
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE  = MEM_WORD_SIZE,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_m,
    input  logic                  write_m,
    input  logic [WORD_SIZE-1:0]  address,
    input  logic [WORD_SIZE-1:0]  write_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [WORD_SIZE-1:0]  load_data,
    output logic [WORD_SIZE-1:0]  read_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  err,
    output logic [WORD_SIZE-1:0]  num_access
);

    localparam int CW = $clog2(LATENCY + 1);

    mem_state_t            r_state;
    mem_state_t            w_next;
    logic [CW-1:0]         r_elapsed;
    logic [CW-1:0]         w_elapsed_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_SIZE-1:0]  r_wdata;
    logic                  r_is_write;
    logic                  r_oor;
    logic [WORD_SIZE-1:0]  r_read_data;
    logic                  r_err;
    logic [WORD_SIZE-1:0]  r_num_access;

    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_violation;
    logic                  w_oor;
    logic                  w_preload;
    logic                  w_commit;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [WORD_SIZE-1:0]  w_wdata;
    logic [WORD_SIZE-1:0]  w_mem_rdata;
    logic [WORD_SIZE-1:0]  w_rd_val;

    assign w_can_accept = (r_state == MEM_IDLE) || (r_state == MEM_DONE);
    assign w_accept     = w_can_accept && (read_m ^ write_m);
    assign w_violation  = w_can_accept && read_m && write_m;
    assign w_oor        = (address >> ADDR_WIDTH) != '0;

    always_comb begin
        w_next         = r_state;
        w_elapsed_next = r_elapsed;
        case (r_state)
            MEM_IDLE, MEM_DONE: begin
                w_next = MEM_IDLE;
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next = MEM_DONE;
                    end else begin
                        w_next         = MEM_WAIT;
                        w_elapsed_next = CW'(1);
                    end
                end
            end
            MEM_WAIT: begin
                w_elapsed_next = r_elapsed + CW'(1);
                if (r_elapsed == CW'(LATENCY - 1)) begin
                    w_next = MEM_DONE;
                end
            end
            default: w_next = MEM_IDLE;
        endcase
    end

    // Reset gates both write sources so an in-flight write is never committed.
    assign w_preload = (r_state == MEM_IDLE) && load_en && !read_m && !write_m && !reset;
    assign w_commit  = (r_state == MEM_DONE) && r_is_write && !r_oor && !reset;
    assign w_we      = w_preload || w_commit;
    assign w_waddr   = w_commit ? r_addr  : load_addr;
    assign w_wdata   = w_commit ? r_wdata : load_data;

    mem_array #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_mem_rdata)
    );

    assign w_rd_val = r_oor ? '0 : w_mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= MEM_IDLE;
            r_elapsed    <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_oor        <= 1'b0;
            r_read_data  <= '0;
            r_err        <= 1'b0;
            r_num_access <= '0;
        end else begin
            r_state   <= w_next;
            r_elapsed <= w_elapsed_next;
            if (w_accept) begin
                r_addr     <= address[ADDR_WIDTH-1:0];
                r_wdata    <= write_data;
                r_is_write <= write_m;
                r_oor      <= w_oor;
            end
            if (w_violation || (w_accept && w_oor)) begin
                r_err <= 1'b1;
            end
            if (r_state == MEM_DONE) begin
                r_num_access <= r_num_access + WORD_SIZE'(1);
                if (!r_is_write) begin
                    r_read_data <= w_rd_val;
                end
            end
        end
    end

    // During a read's DONE cycle the result comes straight from storage; afterwards it is held.
    assign read_data  = ((r_state == MEM_DONE) && !r_is_write) ? w_rd_val : r_read_data;
    assign ready      = (r_state == MEM_DONE);
    assign busy       = (r_state == MEM_WAIT);
    assign err        = r_err;
    assign num_access = r_num_access;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against a transaction-level memory model.
module tb_mem_responder;

    localparam int W   = 16;
    localparam int AW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_m = 1'b0;
    logic          write_m = 1'b0;
    logic [W-1:0]  address = '0;
    logic [W-1:0]  write_data = '0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [W-1:0]  read_data;
    logic          ready;
    logic          busy;
    logic          err;
    logic [W-1:0]  num_access;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_mem [256];
    int           model_num = 0;
    bit           model_err = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(
        .WORD_SIZE  (W),
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_m     (read_m),
        .write_m    (write_m),
        .address    (address),
        .write_data (write_data),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .read_data  (read_data),
        .ready      (ready),
        .busy       (busy),
        .err        (err),
        .num_access (num_access)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        model_mem[a] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Issues one request and returns at the negedge inside the ready cycle (or on timeout).
    task automatic access(input bit wr, input logic [W-1:0] addr, input logic [W-1:0] data,
                          input bit spurious, output int lat, output logic [W-1:0] rdata);
        @(negedge clk);
        read_m = !wr; write_m = wr; address = addr; write_data = data;
        @(negedge clk);
        read_m = 1'b0; write_m = 1'b0;
        if (spurious) begin
            write_m = 1'b1; address = W'($urandom); write_data = W'($urandom);
        end
        lat = 1;
        while (ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        read_m = 1'b0; write_m = 1'b0;
        rdata = read_data;
    endtask

    function automatic logic [W-1:0] expect_read(input logic [W-1:0] addr);
        if ((addr >> AW) != 0) return '0;
        return model_mem[addr[AW-1:0]];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (num_access !== 16'h0) begin n_fail++; $display("FAIL reset_num got=%h exp=0", num_access); end
        n_checks++; if (read_data !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
        reset = 1'b0;
        model_num = 0;
        model_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = AW'(i); load_data = W'($urandom);
            model_mem[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic test_preload_read();
        preload(8'h10, 16'hBEEF);
        @(negedge clk);
        read_m = 1'b1; address = 16'h0010;
        @(negedge clk);
        read_m = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pr_busy got=%b exp=1", busy); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pr_early_ready got=%b exp=0", ready); end
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL pr_ready got=%b exp=1", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pr_busy_done got=%b exp=0", busy); end
        n_checks++; if (read_data !== 16'hBEEF) begin n_fail++; $display("FAIL pr_rdata got=%h exp=beef", read_data); end
        @(negedge clk);
        model_num++;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pr_ready_pulse got=%b exp=0", ready); end
        n_checks++; if (num_access !== W'(model_num)) begin n_fail++; $display("FAIL pr_num got=%h exp=%h", num_access, W'(model_num)); end
        n_checks++; if (read_data !== 16'hBEEF) begin n_fail++; $display("FAIL pr_rdata_hold got=%h exp=beef", read_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL pr_err got=%b exp=0", err); end
    endtask

    task automatic test_back_to_back();
        int           lat;
        logic [W-1:0] rd;
        access(1'b1, 16'h0020, 16'h1234, 1'b0, lat, rd);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_wr_lat got=%0d exp=%0d", lat, LAT); end
        model_mem[8'h20] = 16'h1234;
        read_m = 1'b1; address = 16'h0020;
        @(negedge clk);
        read_m = 1'b0;
        model_num++;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", ready); end
        n_checks++; if (read_data !== 16'h1234) begin n_fail++; $display("FAIL b2b_rdata got=%h exp=1234", read_data); end
        @(negedge clk);
        model_num++;
        n_checks++; if (num_access !== W'(model_num)) begin n_fail++; $display("FAIL b2b_num got=%h exp=%h", num_access, W'(model_num)); end
    endtask

    task automatic test_violation();
        int           lat;
        logic [W-1:0] rd;
        @(negedge clk);
        read_m = 1'b1; write_m = 1'b1; address = 16'h0010; write_data = 16'h0000;
        @(negedge clk);
        read_m = 1'b0; write_m = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL viol_err got=%b exp=1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL viol_busy got=%b exp=0", busy); end
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL viol_ready got=%b exp=0", ready); end
        access(1'b0, 16'h0010, 16'h0, 1'b0, lat, rd);
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL viol_mem got=%h exp=beef", rd); end
        @(negedge clk);
        model_num++;
        n_checks++; if (num_access !== W'(model_num)) begin n_fail++; $display("FAIL viol_num got=%h exp=%h", num_access, W'(model_num)); end
    endtask

    task automatic test_out_of_range();
        int           lat;
        logic [W-1:0] rd;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_num = 0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_clr got=%b exp=0", err); end
        access(1'b1, 16'h0100, 16'h5555, 1'b0, lat, rd);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL oor_wr_lat got=%0d exp=%0d", lat, LAT); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", err); end
        @(negedge clk);
        access(1'b0, 16'h0000, 16'h0, 1'b0, lat, rd);
        n_checks++; if (rd !== model_mem[0]) begin n_fail++; $display("FAIL oor_mem0 got=%h exp=%h", rd, model_mem[0]); end
        @(negedge clk);
        access(1'b0, 16'h0180, 16'h0, 1'b0, lat, rd);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL oor_rd_lat got=%0d exp=%0d", lat, LAT); end
        n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL oor_rd_zero got=%h exp=0", rd); end
        @(negedge clk);
        model_num += 3;
        n_checks++; if (num_access !== W'(model_num)) begin n_fail++; $display("FAIL oor_num got=%h exp=%h", num_access, W'(model_num)); end
    endtask

    task automatic test_reset_mid();
        int           lat;
        logic [W-1:0] rd;
        @(negedge clk);
        write_m = 1'b1; address = 16'h0030; write_data = 16'hAAAA;
        @(negedge clk);
        write_m = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready got=%b exp=0", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got=%b exp=0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rm_err got=%b exp=0", err); end
        n_checks++; if (num_access !== 16'h0) begin n_fail++; $display("FAIL rm_num got=%h exp=0", num_access); end
        n_checks++; if (read_data !== 16'h0) begin n_fail++; $display("FAIL rm_rdata got=%h exp=0", read_data); end
        reset = 1'b0;
        model_num = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rm_no_ready got=%b exp=0", ready); end
        end
        // Reset landing in the DONE cycle of a write must also drop it.
        access(1'b1, 16'h0031, 16'h7777, 1'b0, lat, rd);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 16'h0030, 16'h0, 1'b0, lat, rd);
        n_checks++; if (rd !== model_mem[8'h30]) begin n_fail++; $display("FAIL rm_mem30 got=%h exp=%h", rd, model_mem[8'h30]); end
        @(negedge clk);
        access(1'b0, 16'h0031, 16'h0, 1'b0, lat, rd);
        n_checks++; if (rd !== model_mem[8'h31]) begin n_fail++; $display("FAIL rm_mem31 got=%h exp=%h", rd, model_mem[8'h31]); end
        @(negedge clk);
        model_num = 2;
        n_checks++; if (num_access !== W'(model_num)) begin n_fail++; $display("FAIL rm_num_after got=%h exp=%h", num_access, W'(model_num)); end
    endtask

    task automatic test_random();
        int           lat;
        logic [W-1:0] rd;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic [W-1:0] exp_rd;
        bit           wr;
        bit           oor;
        bit           spur;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) preload(AW'($urandom), W'($urandom));
            wr   = 1'($urandom_range(0, 1));
            oor  = ($urandom_range(0, 7) == 0);
            spur = ($urandom_range(0, 3) == 0);
            addr = oor ? W'($urandom_range(256, 65535)) : W'($urandom_range(0, 255));
            data = W'($urandom);
            exp_rd = expect_read(addr);
            access(wr, addr, data, spur, lat, rd);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_lat n=%0d got=%0d exp=%0d", n, lat, LAT); end
            if (!wr) begin
                n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, addr, rd, exp_rd); end
            end else if (!oor) begin
                model_mem[addr[AW-1:0]] = data;
            end
            model_err = model_err | oor;
            n_checks++; if (err !== model_err) begin n_fail++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, model_err); end
            @(negedge clk);
            model_num++;
            n_checks++; if (num_access !== W'(model_num)) begin n_fail++; $display("FAIL rnd_num n=%0d got=%h exp=%h", n, num_access, W'(model_num)); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_back_to_back();
        test_violation();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
